// File: rtl/sprite_reg_slave_if.sv
// Wishbone classic-cycle bus between an initiator and the sprite register file.
// Request fields are driven by the master; response fields are driven by the slave.
interface sprite_reg_slave_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [7:0]  cid;

  logic        ack;
  logic        err;
  logic        rty;
  logic        stall;
  logic [31:0] rdat;
  logic [7:0]  rcid;

  modport master (
    output cyc, stb, we, sel, adr, dat, cid,
    input  ack, err, rty, stall, rdat, rcid
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat, cid,
    output ack, err, rty, stall, rdat, rcid
  );
endinterface

// File: rtl/sprite_reg_slave.sv
// Double-buffered per-sprite register file behind a Wishbone responder.
// Bus writes land in the shadow bank; the active bank is loaded from shadow on each vsync rise.
module sprite_reg_slave #(
  parameter int unsigned NSPR  = 32,
  parameter int unsigned VBITS = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  sprite_reg_slave_if.slave   wb,
  input  logic                vsync,
  input  logic [4:0]          spr_idx,
  output logic [31:0]         spr_pos,
  output logic [31:0]         spr_size,
  output logic [31:0]         spr_addr,
  output logic [31:0]         spr_en,
  output logic [15:0]         frame_o
);

  localparam int unsigned IW       = $clog2(NSPR);
  localparam logic [5:0]  NSPR6    = 6'(NSPR);
  localparam logic [15:0] HMASK    = 16'((32'd1 << VBITS) - 32'd1);
  localparam logic [31:0] POS_MASK = {HMASK, HMASK};

  typedef enum logic {IDLE, ACK} state_t;

  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] rdat_q, rdat_d;
  logic [7:0]  rcid_q, rcid_d;
  logic        req, acc, spr_hit, look_hit, vsync_q, swap;
  logic [IW-1:0] widx;
  logic [31:0] rd;

  logic [31:0] sh_pos  [NSPR];
  logic [31:0] sh_size [NSPR];
  logic [31:0] sh_addr [NSPR];
  logic [31:0] sh_en;
  logic [31:0] act_pos  [NSPR];
  logic [31:0] act_size [NSPR];
  logic [31:0] act_addr [NSPR];

  logic unused_adr;
  assign unused_adr = ^{wb.adr[31:10], wb.adr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int unsigned i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  assign req      = cs & wb.cyc & wb.stb;
  assign spr_hit  = ~wb.adr[9] && ({1'b0, wb.adr[8:4]} < NSPR6);
  assign widx     = wb.adr[4 +: IW];
  assign look_hit = {1'b0, spr_idx} < NSPR6;
  assign swap     = vsync & ~vsync_q;

  assign wb.ack   = ack_q;
  assign wb.rdat  = rdat_q;
  assign wb.rcid  = rcid_q;
  assign wb.err   = 1'b0;
  assign wb.rty   = 1'b0;
  assign wb.stall = 1'b0;

  always_comb begin
    rd = '0;
    if (!wb.adr[9]) begin
      if (spr_hit) begin
        case (wb.adr[3:2])
          2'd0:    rd = sh_pos[widx];
          2'd1:    rd = sh_size[widx];
          2'd2:    rd = sh_addr[widx];
          default: rd = '0;
        endcase
      end
    end else begin
      case (wb.adr[8:2])
        7'd0:    rd = sh_en;
        7'd1:    rd = {15'b0, vsync, frame_o};
        default: rd = '0;
      endcase
    end
  end

  // The access happens only on the IDLE->ACK transition, so a held strobe never repeats it.
  always_comb begin
    state_d = state_q;
    acc     = 1'b0;
    ack_d   = ack_q;
    rdat_d  = rdat_q;
    rcid_d  = rcid_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = ACK;
        acc     = 1'b1;
        ack_d   = 1'b1;
        rdat_d  = wb.we ? '0 : rd;
        rcid_d  = wb.cid;
      end
      ACK: if (!req) begin
        state_d = IDLE;
        ack_d   = 1'b0;
        rdat_d  = '0;
        rcid_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      rcid_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      rcid_q  <= rcid_d;
    end
  end

  // Swap and write share this block: active takes the pre-write shadow on a coinciding edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NSPR; i++) begin
        sh_pos[i]   <= '0;
        sh_size[i]  <= '0;
        sh_addr[i]  <= '0;
        act_pos[i]  <= '0;
        act_size[i] <= '0;
        act_addr[i] <= '0;
      end
      sh_en   <= '0;
      spr_en  <= '0;
      frame_o <= '0;
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (swap) begin
        for (int unsigned i = 0; i < NSPR; i++) begin
          act_pos[i]  <= sh_pos[i];
          act_size[i] <= sh_size[i];
          act_addr[i] <= sh_addr[i];
        end
        spr_en  <= sh_en;
        frame_o <= frame_o + 16'd1;
      end
      if (acc && wb.we) begin
        if (spr_hit) begin
          case (wb.adr[3:2])
            2'd0:    sh_pos[widx]  <= merge(sh_pos[widx], wb.dat, wb.sel) & POS_MASK;
            2'd1:    sh_size[widx] <= merge(sh_size[widx], wb.dat, wb.sel);
            2'd2:    sh_addr[widx] <= merge(sh_addr[widx], wb.dat, wb.sel);
            default: ;
          endcase
        end else if (wb.adr[9] && wb.adr[8:2] == 7'd0) begin
          sh_en <= merge(sh_en, wb.dat, wb.sel);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spr_pos  <= '0;
      spr_size <= '0;
      spr_addr <= '0;
    end else if (look_hit) begin
      spr_pos  <= act_pos[spr_idx[IW-1:0]];
      spr_size <= act_size[spr_idx[IW-1:0]];
      spr_addr <= act_addr[spr_idx[IW-1:0]];
    end else begin
      spr_pos  <= '0;
      spr_size <= '0;
      spr_addr <= '0;
    end
  end

endmodule

// File: tb/tb_sprite_reg_slave.sv
// Directed bench for sprite_reg_slave: bus transfers, bank swap timing and async reset.
module tb_sprite_reg_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        vsync;
  logic [4:0]  spr_idx;
  logic [31:0] spr_pos, spr_size, spr_addr, spr_en;
  logic [15:0] frame_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_q [$];
  logic [15:0] frame_exp = 16'd0;
  logic [7:0]  cid_n = 8'h10;

  sprite_reg_slave_if wb ();

  sprite_reg_slave #(.NSPR(32), .VBITS(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .wb       (wb),
    .vsync    (vsync),
    .spr_idx  (spr_idx),
    .spr_pos  (spr_pos),
    .spr_size (spr_size),
    .spr_addr (spr_addr),
    .spr_en   (spr_en),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    cid_n++;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = w;
    wb.adr = a; wb.dat = d; wb.sel = s; wb.cid = cid_n;
  endtask

  task automatic drop_req();
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    wb.adr = '0; wb.dat = '0; wb.sel = '0;
  endtask

  // Single-cycle strobe: ack expected at the next sample, cleared one sample later.
  task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp);
    logic [31:0] e;
    if (!w) exp_q.push_back(exp);
    drive_req(w, a, d, s);
    @(negedge clk);
    check({tag, "_ack"}, {31'b0, wb.ack}, 32'd1);
    check({tag, "_cid"}, {24'b0, wb.rcid}, {24'b0, cid_n});
    if (!w) begin
      e = exp_q.pop_front();
      check({tag, "_rd"}, wb.rdat, e);
    end
    drop_req();
    @(negedge clk);
    check({tag, "_ackfall"}, {31'b0, wb.ack}, 32'd0);
    check({tag, "_datfall"}, wb.rdat, 32'd0);
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    frame_exp++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; vsync = 1'b0; spr_idx = 5'd0;
    drop_req(); wb.cid = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", {31'b0, wb.ack}, 32'd0);
    check("rst_frame", {16'b0, frame_o}, 32'd0);
    check("rst_en", spr_en, 32'd0);
    check("rst_pos", spr_pos, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    xfer("rd_pos3", 1'b0, 32'h030, '0, 4'hF, 32'h0);

    spr_idx = 5'd5;
    xfer("wr_size5", 1'b1, 32'h054, 32'h8A031518, 4'hF, '0);
    xfer("rb_size5", 1'b0, 32'h054, '0, 4'hF, 32'h8A031518);
    check("size5_pre", spr_size, 32'h0);
    vsync = 1'b1;
    @(negedge clk);
    check("size5_swapedge", spr_size, 32'h0);
    vsync = 1'b0;
    frame_exp++;
    @(negedge clk);
    check("size5_post", spr_size, 32'h8A031518);
    check("frame_1", {16'b0, frame_o}, {16'b0, frame_exp});

    xfer("wr_size5_lane2", 1'b1, 32'h054, 32'h00FF0000, 4'b0100, '0);
    xfer("rb_size5_lane2", 1'b0, 32'h054, '0, 4'hF, 32'h8AFF1518);
    check("size5_active_hold", spr_size, 32'h8A031518);

    xfer("wr_pos0", 1'b1, 32'h000, 32'hF064F0C8, 4'hF, '0);
    xfer("rb_pos0", 1'b0, 32'h000, '0, 4'hF, 32'h006400C8);

    xfer("wr_en", 1'b1, 32'h200, 32'hFFFFFFFF, 4'b0011, '0);
    xfer("rb_en", 1'b0, 32'h200, '0, 4'hF, 32'h0000FFFF);
    check("en_pre", spr_en, 32'h0);
    vs_pulse();
    check("en_post", spr_en, 32'h0000FFFF);
    check("size5_lane2_post", spr_size, 32'h8AFF1518);
    xfer("rd_status", 1'b0, 32'h204, '0, 4'hF, {16'b0, frame_exp});

    spr_idx = 5'd0;
    @(negedge clk);
    check("pos0_post", spr_pos, 32'h006400C8);

    spr_idx = 5'd31;
    xfer("wr_addr31_a", 1'b1, 32'h1F8, 32'h11112222, 4'hF, '0);
    vs_pulse();
    check("addr31_a", spr_addr, 32'h11112222);
    vsync = 1'b1;
    drive_req(1'b1, 32'h1F8, 32'h33334444, 4'hF);
    @(negedge clk);
    check("wr_addr31_b_ack", {31'b0, wb.ack}, 32'd1);
    drop_req();
    vsync = 1'b0;
    frame_exp++;
    @(negedge clk);
    check("addr31_coincide_old", spr_addr, 32'h11112222);
    check("frame_coincide", {16'b0, frame_o}, {16'b0, frame_exp});
    xfer("rb_addr31_b", 1'b0, 32'h1F8, '0, 4'hF, 32'h33334444);
    vs_pulse();
    check("addr31_b", spr_addr, 32'h33334444);
    check("frame_next", {16'b0, frame_o}, {16'b0, frame_exp});

    xfer("wr_rsv_spr", 1'b1, 32'h01C, 32'hA5A5A5A5, 4'hF, '0);
    xfer("rd_rsv_spr", 1'b0, 32'h01C, '0, 4'hF, 32'h0);
    xfer("wr_rsv_20c", 1'b1, 32'h20C, 32'h5A5A5A5A, 4'hF, '0);
    xfer("rd_rsv_20c", 1'b0, 32'h20C, '0, 4'hF, 32'h0);
    xfer("rd_hi_adr", 1'b0, 32'hFFFFFC00, '0, 4'hF, 32'h006400C8);

    drive_req(1'b1, 32'h024, 32'h12345678, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_ack", {31'b0, wb.ack}, 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ack", {31'b0, wb.ack}, 32'd0);
    check("rst_mid_frame", {16'b0, frame_o}, 32'd0);
    check("rst_mid_en", spr_en, 32'd0);
    frame_exp = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rerun_ack", {31'b0, wb.ack}, 32'd1);
    drop_req();
    @(negedge clk);
    check("rerun_ackfall", {31'b0, wb.ack}, 32'd0);
    xfer("rb_size2", 1'b0, 32'h024, '0, 4'hF, 32'h12345678);
    xfer("rb_size5_cleared", 1'b0, 32'h054, '0, 4'hF, 32'h0);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
